// File: rtl/led_display_pkg.sv
// led_display_pkg: mode encodings and page-geometry helpers for the LED scanner
package led_display_pkg;
  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_FLAGS  = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;
  function automatic int pages_of(int data_w, int led_w);
    return data_w / led_w;
  endfunction
  function automatic int pw_of(int pages);
    return pages > 1 ? $clog2(pages) : 1;
  endfunction
endpackage

// File: rtl/led_display_prescaler.sv
// led_display_prescaler: divide-by-PAGE_DIV counter producing the auto-scan page tick
// ports: clk, rst_n (async, active-low), en (count), clr (sync restart at 0), tick (last count while enabled)
module led_display_prescaler #(
  parameter int PAGE_DIV = 50_000_000,
  localparam int CW = $clog2(PAGE_DIV)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(PAGE_DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/led_display_scan.sv
// led_display_scan: snapshots an ALU result and scans it page-by-page onto an LED bank
// ports: clk/rst_n (async, active-low), data/overflow/zero sampled on load, clear drops sticky overflow,
//        mode selects MANUAL/AUTO/FLAGS/HOLD, SW picks the page in MANUAL, F drives LEDs, page/tick report scan
module led_display_scan
  import led_display_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int LED_W    = 8,
  parameter int PAGE_DIV = 50_000_000,
  localparam int PAGES = pages_of(DATA_W, LED_W),
  localparam int PW    = pw_of(PAGES)
) (
  input  logic              LED_DISPLAY_SCAN_clk_xi,
  input  logic              LED_DISPLAY_SCAN_rst_n_xi,
  input  logic [DATA_W-1:0] LED_DISPLAY_SCAN_data_xi,
  input  logic              LED_DISPLAY_SCAN_overflow_flag_xi,
  input  logic              LED_DISPLAY_SCAN_zero_flag_xi,
  input  logic              LED_DISPLAY_SCAN_load_xi,
  input  logic              LED_DISPLAY_SCAN_clear_xi,
  input  logic [1:0]        LED_DISPLAY_SCAN_mode_xi,
  input  logic [2:0]        LED_DISPLAY_SCAN_SW_xi,
  output logic [LED_W-1:0]  LED_DISPLAY_SCAN_F_xo,
  output logic [PW-1:0]     LED_DISPLAY_SCAN_page_xo,
  output logic              LED_DISPLAY_SCAN_tick_xo
);
  mode_e mode;
  logic [DATA_W-1:0] snap;
  logic zero_cap, ovf, tick;
  logic [PW-1:0] sw_clamp, page_adv, page_n;
  logic [LED_W-1:0] f_n;
  assign mode = mode_e'(LED_DISPLAY_SCAN_mode_xi);
  assign LED_DISPLAY_SCAN_tick_xo = tick;
  // any non-AUTO mode parks the prescaler at 0, so every entry into AUTO starts a fresh page period
  led_display_prescaler #(.PAGE_DIV(PAGE_DIV)) u_prescaler (
    .clk  (LED_DISPLAY_SCAN_clk_xi),
    .rst_n(LED_DISPLAY_SCAN_rst_n_xi),
    .en   (mode == MODE_AUTO),
    .clr  (mode != MODE_AUTO),
    .tick (tick)
  );
  always_comb begin
    sw_clamp = 32'(LED_DISPLAY_SCAN_SW_xi) >= PAGES ? PW'(PAGES - 1) : PW'(LED_DISPLAY_SCAN_SW_xi);
    page_adv = LED_DISPLAY_SCAN_page_xo == PW'(PAGES - 1) ? '0 : LED_DISPLAY_SCAN_page_xo + 1'b1;
    page_n   = mode == MODE_MANUAL ? sw_clamp : tick ? page_adv : LED_DISPLAY_SCAN_page_xo;
    f_n      = (mode == MODE_MANUAL || mode == MODE_AUTO) ? snap[int'(LED_DISPLAY_SCAN_page_xo)*LED_W +: LED_W] :
               mode == MODE_FLAGS ? {{(LED_W-2){1'b0}}, zero_cap, ovf} : LED_DISPLAY_SCAN_F_xo;
  end
  always_ff @(posedge LED_DISPLAY_SCAN_clk_xi or negedge LED_DISPLAY_SCAN_rst_n_xi)
    if (!LED_DISPLAY_SCAN_rst_n_xi) begin
      snap                     <= '0;
      zero_cap                 <= 1'b0;
      ovf                      <= 1'b0;
      LED_DISPLAY_SCAN_page_xo <= '0;
      LED_DISPLAY_SCAN_F_xo    <= '0;
    end else begin
      if (LED_DISPLAY_SCAN_load_xi) begin
        snap     <= LED_DISPLAY_SCAN_data_xi;
        zero_cap <= LED_DISPLAY_SCAN_zero_flag_xi;
      end
      ovf                      <= (ovf & ~LED_DISPLAY_SCAN_clear_xi) | (LED_DISPLAY_SCAN_load_xi & LED_DISPLAY_SCAN_overflow_flag_xi);
      LED_DISPLAY_SCAN_page_xo <= page_n;
      LED_DISPLAY_SCAN_F_xo    <= f_n;
    end
endmodule

// File: tb/tb_led_display_scan.sv
// tb_led_display_scan: directed and randomized checks of led_display_scan against a behavioural model
module tb_led_display_scan;
  localparam int PD = 4, NP = 4;
  logic clk = 0, rst_n = 0;
  logic [31:0] data = 0;
  logic of = 0, zf = 0, load = 0, clear = 0;
  logic [1:0] mode = 0;
  logic [2:0] sw = 0;
  logic [7:0] f;
  logic [1:0] page;
  logic tick;
  int total = 0, bad = 0;
  logic [31:0] m_snap;
  logic m_zc, m_ovf;
  int m_page, m_cnt;
  logic [7:0] m_f;
  int sws[5] = '{0, 1, 2, 3, 5};
  int pgs[5] = '{0, 1, 2, 3, 3};
  logic [7:0] fxs[5] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h12};
  int pg_s;
  logic [7:0] f_s;

  led_display_scan #(.DATA_W(32), .LED_W(8), .PAGE_DIV(PD)) dut (
    .LED_DISPLAY_SCAN_clk_xi          (clk),
    .LED_DISPLAY_SCAN_rst_n_xi        (rst_n),
    .LED_DISPLAY_SCAN_data_xi         (data),
    .LED_DISPLAY_SCAN_overflow_flag_xi(of),
    .LED_DISPLAY_SCAN_zero_flag_xi    (zf),
    .LED_DISPLAY_SCAN_load_xi         (load),
    .LED_DISPLAY_SCAN_clear_xi        (clear),
    .LED_DISPLAY_SCAN_mode_xi         (mode),
    .LED_DISPLAY_SCAN_SW_xi           (sw),
    .LED_DISPLAY_SCAN_F_xo            (f),
    .LED_DISPLAY_SCAN_page_xo         (page),
    .LED_DISPLAY_SCAN_tick_xo         (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_snap = 0; m_zc = 0; m_ovf = 0; m_page = 0; m_cnt = 0; m_f = 0;
  endtask

  // m_cnt counts AUTO cycles since entering AUTO, modulo PD
  task automatic step();
    logic tk;
    @(posedge clk);
    tk = (mode == 1) && (m_cnt == PD - 1);
    if (mode == 0 || mode == 1) m_f = 8'((m_snap >> (8 * m_page)) & 32'hFF);
    else if (mode == 2) m_f = {6'b0, m_zc, m_ovf};
    if (mode == 0) m_page = (int'(sw) >= NP) ? NP - 1 : int'(sw);
    else if (tk) m_page = (m_page + 1) % NP;
    m_cnt = (mode == 1) ? (m_cnt + 1) % PD : 0;
    m_ovf = (m_ovf & ~clear) | (load & of);
    if (load) begin m_snap = data; m_zc = zf; end
    #1;
    chk("F", f, m_f);
    chk("page", page, m_page);
    chk("tick", tick, (mode == 1 && m_cnt == PD - 1));
  endtask

  task automatic idle(int n);
    load = 0; clear = 0;
    repeat (n) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    m_reset();
    #12;
    chk("rst_F", f, 0);
    chk("rst_page", page, 0);
    chk("rst_tick", tick, 0);
    @(negedge clk);
    rst_n = 1;
    data = 32'hFFFF_FFFF; load = 1;
    step();
    load = 0;
    chk("load_pre", f, 8'h00);
    step();
    chk("load_lat2", f, 8'hFF);
    data = 32'h1234_5678; load = 1;
    step();
    load = 0;
    for (int i = 0; i < 5; i++) begin
      sw = 3'(sws[i]);
      step();
      chk("man_page", page, pgs[i]);
      step();
      chk("man_F", f, fxs[i]);
    end
    sw = 0;
    idle(2);
    mode = 1;
    for (int p = 1; p <= 4; p++) begin
      repeat (3) step();
      chk("auto_tick", tick, 1);
      step();
      chk("auto_page", page, p % 4);
    end
    repeat (2) step();
    pg_s = int'(page);
    step();
    f_s = f;
    mode = 3;
    repeat (10) begin
      step();
      chk("hold_page", page, pg_s);
      chk("hold_F", f, f_s);
    end
    mode = 1;
    repeat (3) step();
    chk("resume_tick", tick, 1);
    step();
    chk("resume_page", page, (pg_s + 1) % 4);
    mode = 2; of = 1; load = 1;
    step();
    of = 0;
    step();
    load = 0;
    step();
    chk("flags_sticky", f, 8'h01);
    clear = 1;
    step();
    clear = 0;
    step();
    chk("flags_clear", f, 8'h00);
    load = 1; zf = 1;
    step();
    load = 0; zf = 0;
    step();
    chk("flags_zero", f, 8'h02);
    clear = 1; load = 1; of = 1;
    step();
    clear = 0; load = 0; of = 0;
    step();
    chk("flags_clr_set", f, 8'h01);
    mode = 1; data = 32'h1234_5678; load = 1;
    step();
    idle(6);
    #2 rst_n = 0;
    #1;
    chk("async_F", f, 0);
    chk("async_page", page, 0);
    chk("async_tick", tick, 0);
    m_reset();
    #2 rst_n = 1;
    idle(3);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
      sw    = 3'($urandom_range(7));
      data  = $urandom;
      load  = ($urandom_range(3) == 0);
      of    = 1'($urandom_range(1));
      zf    = 1'($urandom_range(1));
      clear = ($urandom_range(7) == 0);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/led_display_scan.md
LED_DISPLAY_SCAN -- requirements
Module: led_display_scan

Interface
REQ-001 Parameter DATA_W, default 32: width of captured data word; SHALL be a multiple of LED_W.
REQ-002 Parameter LED_W, default 8: LED bank width; PAGES = DATA_W/LED_W, PW = max(1, clog2(PAGES)).
REQ-003 Parameter PAGE_DIV, default 50_000_000: clocks per auto-scan page; SHALL be >= 2.
REQ-004 The clock SHALL be LED_DISPLAY_SCAN_clk_xi (input, 1 bit), the sole clock; all state on rising edge.
REQ-005 The reset SHALL be LED_DISPLAY_SCAN_rst_n_xi (input, 1 bit), asynchronous, active-low.
REQ-006 LED_DISPLAY_SCAN_data_xi  input  DATA_W  word to display, sampled on load.
REQ-007 LED_DISPLAY_SCAN_overflow_flag_xi  input  1  ALU overflow, sampled on load.
REQ-008 LED_DISPLAY_SCAN_zero_flag_xi  input  1  ALU zero, sampled on load.
REQ-009 LED_DISPLAY_SCAN_load_xi  input  1  single-cycle strobe capturing data and flags.
REQ-010 LED_DISPLAY_SCAN_clear_xi  input  1  clears sticky overflow.
REQ-011 LED_DISPLAY_SCAN_mode_xi  input  2  00 MANUAL, 01 AUTO, 10 FLAGS, 11 HOLD.
REQ-012 LED_DISPLAY_SCAN_SW_xi  input  3  page select in MANUAL.
REQ-013 LED_DISPLAY_SCAN_F_xo  output  LED_W  registered LED drive.
REQ-014 LED_DISPLAY_SCAN_page_xo  output  PW  current page index.
REQ-015 LED_DISPLAY_SCAN_tick_xo  output  1  one-cycle pulse on each auto page advance.

Function
REQ-016 On load_xi=1 the snapshot register SHALL take data_xi and zero_cap SHALL take zero_flag_xi next edge; with load_xi=0 both hold.
REQ-017 Sticky overflow SHALL update as ovf <= (ovf & ~clear_xi) | (load_xi & overflow_flag_xi); simultaneous clear and set leaves ovf=1.
REQ-018 Page p SHALL denote snapshot bits [p*LED_W +: LED_W]; page 0 is least significant.
REQ-019 MANUAL: page SHALL register SW_xi each cycle, clamped to PAGES-1 when SW_xi >= PAGES; prescaler held at 0.
REQ-020 AUTO: prescaler SHALL count 0..PAGE_DIV-1 and wrap; at count PAGE_DIV-1 tick_xo=1 for that cycle and page advances next edge, wrapping PAGES-1 -> 0.
REQ-021 Entering AUTO from any other mode SHALL restart prescaler at 0 and continue from the current page.
REQ-022 FLAGS: F_xo SHALL be {LED_W-2 zeros, zero_cap, ovf}; page and prescaler hold.
REQ-023 HOLD: page, prescaler and F_xo SHALL freeze; load and clear still update snapshot/flags.
REQ-024 In MANUAL/AUTO, F_xo SHALL register the selected page of the snapshot each cycle.
REQ-025 Latency: load -> F_xo change 2 cycles; SW_xi change -> F_xo change 2 cycles; page_xo leads F_xo by 1 cycle.
REQ-026 tick_xo SHALL be 0 outside AUTO.
REQ-027 With PAGES=1 the page SHALL remain 0 in all modes; ticks still occur in AUTO.

Reset
REQ-028 Reset assertion SHALL immediately (no clock) force snapshot, zero_cap, ovf, page, prescaler, F_xo and tick_xo to 0.
REQ-029 After deassertion the first edge SHALL behave per mode; reset mid-scan loses no further state beyond REQ-028.

Structure
REQ-030 Package led_display_pkg SHALL hold mode encodings (MODE_MANUAL/AUTO/FLAGS/HOLD) and the PAGES/PW derivation function.
REQ-031 Sub-module led_display_prescaler (enable, sync clear, tick out, parameter PAGE_DIV) SHALL implement the page counter.

Verification (DATA_W=32, LED_W=8, PAGE_DIV=4)
REQ-032 Reset, MANUAL SW=0, load 32'hFFFF_FFFF -> F_xo=8'hFF exactly 2 cycles after load, 8'h00 before.
REQ-033 Load 32'h1234_5678, MANUAL SW=0,1,2,3,5 -> F_xo 78,56,34,12,12 (clamp), page_xo 0,1,2,3,3.
REQ-034 AUTO from page 0 -> page_xo 0,1,2,3,0 every 4 clocks, F_xo 78,56,34,12,78, tick_xo one cycle per advance.
REQ-035 FLAGS: load ovf=1, then load ovf=0 -> F_xo=8'h01; clear -> 8'h00; load zero=1 -> 8'h02; clear with load ovf=1 same cycle -> 8'h01.
REQ-036 AUTO then HOLD 10 cycles mid-page -> page_xo/F_xo constant, tick_xo=0; back to AUTO -> next advance after exactly 4 clocks.
REQ-037 Assert rst_n low between clock edges mid-scan -> F_xo, page_xo, tick_xo read 0 before next edge.
